// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sb_pkg
// Description : Shared defaults, pointer-width helper and entry type for the
//               MEM-stage store buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package sb_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    function automatic int sb_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int SB_PTR_W = sb_ptr_w(SB_DEPTH);
    localparam int SB_CNT_W = SB_PTR_W + 1;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage : sb_pkg
`default_nettype wire

// File: rtl/sb_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : sb_fwd_match
// Description : Youngest-first word-address match of a load against the live
//               entries of the store FIFO; returns hit flag and matching data.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter  int DEPTH  = SB_DEPTH,
    parameter  int ADDR_W = SB_ADDR_W,
    parameter  int DATA_W = SB_DATA_W,
    localparam int PTR_W  = sb_ptr_w(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  sb_entry_t         i_entries [DEPTH],
    input  logic [PTR_W-1:0]  i_head,
    input  logic [CNT_W-1:0]  i_count,
    input  logic [ADDR_W-1:0] i_load_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    localparam logic [ADDR_W-1:0] c_WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    // Walk oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < i_count) begin
                if (((i_entries[i_head + PTR_W'(i)].addr ^ i_load_addr) & c_WORD_MASK) == '0) begin
                    o_hit  = 1'b1;
                    o_data = i_entries[i_head + PTR_W'(i)].data;
                end
            end
        end
    end

endmodule : sb_fwd_match
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : In-order store FIFO owning the data-memory port; drains in
//               load-free cycles and forwards buffered data to same-cycle loads.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
    import sb_pkg::*;
#(
    parameter  int DEPTH  = SB_DEPTH,
    parameter  int ADDR_W = SB_ADDR_W,
    parameter  int DATA_W = SB_DATA_W,
    localparam int PTR_W  = sb_ptr_w(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              store_valid_i,
    input  logic [ADDR_W-1:0] store_addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic              load_valid_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    output logic [DATA_W-1:0] load_data_o,
    output logic              load_fwd_o,
    output logic              stall_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              mem_wr_o,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    sb_entry_t          r_entries [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    sb_entry_t          w_head_entry;
    logic               w_pop;
    logic               w_space;
    logic               w_push;
    logic               w_fwd_hit;
    logic [DATA_W-1:0]  w_fwd_data;

    assign w_head_entry = r_entries[r_head];

    // The load always owns the port; the head drains only in load-free cycles.
    assign w_pop   = !load_valid_i && (r_count != '0);
    assign w_space = (r_count < CNT_W'(DEPTH)) || w_pop;
    assign w_push  = store_valid_i && w_space;

    assign stall_o    = rst_i && store_valid_i && !w_space;
    assign mem_wr_o   = rst_i && w_pop;
    assign mem_re_o   = rst_i && load_valid_i;
    assign mem_adr_o  = load_valid_i ? load_addr_i : w_head_entry.addr;
    assign mem_data_o = w_head_entry.data;

    assign empty_o = (r_count == '0);
    assign count_o = r_count;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Entry storage needs no reset: validity is defined solely by head/count.
    always_ff @(posedge clk_i) begin
        if (rst_i && w_push) begin
            r_entries[r_tail].addr <= store_addr_i;
            r_entries[r_tail].data <= store_data_i;
        end
    end

    sb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd_match (
        .i_entries   (r_entries),
        .i_head      (r_head),
        .i_count     (r_count),
        .i_load_addr (load_addr_i),
        .o_hit       (w_fwd_hit),
        .o_data      (w_fwd_data)
    );

    assign load_fwd_o  = w_fwd_hit;
    assign load_data_o = w_fwd_hit ? w_fwd_data : mem_data_i;

endmodule : store_buffer
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Directed self-checking bench for store_buffer (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
    import sb_pkg::*;

    logic                clk = 1'b0;
    logic                r_rst_n;
    logic                r_store_valid;
    logic [31:0]         r_store_addr;
    logic [31:0]         r_store_data;
    logic                r_load_valid;
    logic [31:0]         r_load_addr;
    logic [31:0]         r_mem_rdata;
    logic [31:0]         w_load_data;
    logic                w_load_fwd;
    logic                w_stall;
    logic                w_empty;
    logic [SB_CNT_W-1:0] w_count;
    logic                w_mem_wr;
    logic                w_mem_re;
    logic [31:0]         w_mem_adr;
    logic [31:0]         w_mem_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    store_buffer u_dut (
        .clk_i         (clk),
        .rst_i         (r_rst_n),
        .store_valid_i (r_store_valid),
        .store_addr_i  (r_store_addr),
        .store_data_i  (r_store_data),
        .load_valid_i  (r_load_valid),
        .load_addr_i   (r_load_addr),
        .load_data_o   (w_load_data),
        .load_fwd_o    (w_load_fwd),
        .stall_o       (w_stall),
        .empty_o       (w_empty),
        .count_o       (w_count),
        .mem_wr_o      (w_mem_wr),
        .mem_re_o      (w_mem_re),
        .mem_adr_o     (w_mem_adr),
        .mem_data_o    (w_mem_data),
        .mem_data_i    (r_mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la);
        @(negedge clk);
        r_store_valid = sv;
        r_store_addr  = sa;
        r_store_data  = sd;
        r_load_valid  = lv;
        r_load_addr   = la;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_adr [4];
        logic [31:0] exp_dat [4];
        exp_adr = '{32'h20, 32'h30, 32'h34, 32'h38};
        exp_dat = '{32'h2222_2222, 32'h3333_3333, 32'h3434_3434, 32'h3838_3838};

        r_rst_n = 1'b0;
        r_store_valid = 1'b0; r_store_addr = '0; r_store_data = '0;
        r_load_valid = 1'b0;  r_load_addr = '0;  r_mem_rdata = '0;
        repeat (2) @(negedge clk);
        r_rst_n = 1'b1;

        // Random stores fill the buffer while loads keep the port busy
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'($urandom_range(0, 255)) << 2, $urandom, 1'b1, 32'h1000);
        end

        // Test 1: reset with a full buffer and store/load still asserted
        drive(1'b1, 32'h200, 32'h1, 1'b1, 32'h1000);
        r_rst_n = 1'b0;
        #1;
        check("t1_stall_forced", w_stall, 0);
        check("t1_re_forced", w_mem_re, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("t1_count_zero", w_count, 0);
        check("t1_empty", w_empty, 1);
        check("t1_wr_low", w_mem_wr, 0);
        @(negedge clk);
        r_rst_n = 1'b1;
        #1;
        check("t1_count_after", w_count, 0);
        check("t1_stall_after", w_stall, 0);

        // Test 2: single store drains on the following cycle
        drive(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
        check("t2_no_wr_yet", w_mem_wr, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("t2_count1", w_count, 1);
        check("t2_wr", w_mem_wr, 1);
        check("t2_adr", w_mem_adr, 32'h10);
        check("t2_data", w_mem_data, 32'hDEAD_BEEF);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("t2_empty", w_empty, 1);
        check("t2_wr_idle", w_mem_wr, 0);

        // Test 3: two stores to the same word, youngest forwarded
        r_mem_rdata = 32'h5555_5555;
        drive(1'b1, 32'h20, 32'h1111_1111, 1'b1, 32'h20);
        check("t3_same_cycle_invisible", w_load_fwd, 0);
        check("t3_mem_data_through", w_load_data, 32'h5555_5555);
        check("t3_re", w_mem_re, 1);
        check("t3_re_adr", w_mem_adr, 32'h20);
        drive(1'b1, 32'h20, 32'h2222_2222, 1'b1, 32'h20);
        check("t3_older_fwd", w_load_data, 32'h1111_1111);
        check("t3_older_fwd_flag", w_load_fwd, 1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
        check("t3_youngest_fwd", w_load_data, 32'h2222_2222);
        check("t3_fwd_flag", w_load_fwd, 1);
        check("t3_count2", w_count, 2);
        check("t3_wr_blocked", w_mem_wr, 0);

        // Test 4: fill to DEPTH under loads, then stall and drain-accept
        drive(1'b1, 32'h30, 32'h3333_3333, 1'b1, 32'h20);
        drive(1'b1, 32'h34, 32'h3434_3434, 1'b1, 32'h20);
        check("t4_count3", w_count, 3);
        check("t4_no_stall", w_stall, 0);
        drive(1'b1, 32'h38, 32'h3838_3838, 1'b1, 32'h34);
        check("t4_stall", w_stall, 1);
        check("t4_count_full", w_count, 4);
        check("t4_wrap_fwd", w_load_data, 32'h3434_3434);
        check("t4_wrap_fwd_flag", w_load_fwd, 1);
        drive(1'b1, 32'h38, 32'h3838_3838, 1'b1, 32'h34);
        check("t4_still_stall", w_stall, 1);
        check("t4_still_full", w_count, 4);
        drive(1'b1, 32'h38, 32'h3838_3838, 1'b0, 32'h0);
        check("t4_accept_stall", w_stall, 0);
        check("t4_drain_wr", w_mem_wr, 1);
        check("t4_drain_adr", w_mem_adr, 32'h20);
        check("t4_drain_data", w_mem_data, 32'h1111_1111);

        // Test 5: load miss while buffer holds other words
        r_mem_rdata = 32'hCAFE_F00D;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
        check("t5_count_held", w_count, 4);
        check("t5_re", w_mem_re, 1);
        check("t5_wr_low", w_mem_wr, 0);
        check("t5_adr", w_mem_adr, 32'h40);
        check("t5_data", w_load_data, 32'hCAFE_F00D);
        check("t5_fwd", w_load_fwd, 0);

        // Remaining entries drain in FIFO order, one per load-free cycle
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
            check($sformatf("drain%0d_wr", k), w_mem_wr, 1);
            check($sformatf("drain%0d_adr", k), w_mem_adr, exp_adr[k]);
            check($sformatf("drain%0d_data", k), w_mem_data, exp_dat[k]);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("drain_empty", w_empty, 1);
        check("drain_wr_idle", w_mem_wr, 0);

        // Test 6: reset discards buffered stores
        r_mem_rdata = 32'h0;
        drive(1'b1, 32'h60, 32'h6060_6060, 1'b1, 32'h100);
        drive(1'b1, 32'h64, 32'h6464_6464, 1'b1, 32'h100);
        drive(1'b1, 32'h68, 32'h6868_6868, 1'b1, 32'h100);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("t6_count3", w_count, 3);
        r_rst_n = 1'b0;
        #1;
        check("t6_wr_forced", w_mem_wr, 0);
        @(negedge clk);
        r_rst_n = 1'b1;
        #1;
        check("t6_count_zero", w_count, 0);
        check("t6_empty", w_empty, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
            check($sformatf("t6_no_wr%0d", k), w_mem_wr, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_store_buffer
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits in the MEM stage directly upstream of the data memory and owns that memory's single port: MemWr_i, MemRe_i, Adr_i, data_i, data_o.
- Retires stores into a small in-order FIFO and drains them to memory in cycles with no load.
- Loads are served in the same cycle, with store-to-load forwarding from the buffer.
- Raises a pipeline stall when a store cannot be accepted.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- ADDR_W, 32, address width
- DATA_W, 32, data width (one word per entry)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-low
- store_valid_i  in  1  store request from EX/MEM
- store_addr_i  in  ADDR_W  store byte address, word-aligned
- store_data_i  in  DATA_W  store data
- load_valid_i  in  1  load request from EX/MEM
- load_addr_i  in  ADDR_W  load byte address, word-aligned
- load_data_o  out  DATA_W  load result, combinational, same cycle
- load_fwd_o  out  1  load_data_o came from the buffer
- stall_o  out  1  store not accepted this cycle; pipeline must hold
- empty_o  out  1  buffer empty (for halt/fence)
- count_o  out  $clog2(DEPTH)+1  current occupancy
- mem_wr_o  out  1  to memory write enable
- mem_re_o  out  1  to memory read enable
- mem_adr_o  out  ADDR_W  to memory address
- mem_data_o  out  DATA_W  to memory write data
- mem_data_i  in  DATA_W  from memory read data

Behaviour:
- **State:** entry array (addr, data); head, tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; count register.
- **Reset** (rst_i=0 at a clk_i edge): head=tail=count=0; all buffered stores discarded, none written to memory.
  - While rst_i=0, mem_wr_o and mem_re_o are forced 0 and stall_o is forced 0.
  - load_data_o and load_fwd_o are don't-care during reset.
- **Port arbitration (combinational):**
  - If load_valid_i=1: mem_re_o=1, mem_adr_o=load_addr_i, mem_wr_o=0. The load always wins the port.
  - Else if count≠0: mem_wr_o=1, mem_adr_o=head.addr, mem_data_o=head.data; pop at the edge (head++, count−1).
  - Else: mem_wr_o=0, mem_re_o=0.
  - Address and data are held stable for the whole write cycle, because the memory is level-sensitive.
- **Push:**
  - pop = !load_valid_i & count≠0.
  - space = (count<DEPTH) | pop.
  - A store is accepted at the edge when store_valid_i & space: write the entry at tail, tail++.
  - If store_valid_i & !space: stall_o=1 and nothing is written.
  - count_next = count + push − pop, so a simultaneous push and pop leaves count unchanged.
- **Forwarding:**
  - Compare load_addr_i[ADDR_W-1:2] against every valid entry.
  - On a hit, the youngest matching entry wins: load_data_o = that entry's data, load_fwd_o=1.
  - On a miss: load_data_o = mem_data_i, load_fwd_o=0.
  - A store pushed in the same cycle is not visible to that cycle's load.
- **Ordering:** stores reach memory strictly in FIFO order, one per non-load cycle.
- **Simultaneous store_valid_i and load_valid_i:** both are handled independently per the rules above.
- **Illegal input:** address bits [1:0] ≠ 0 is illegal. The address is passed through unmodified; the bench flags it.
- **Derived outputs:** empty_o = (count==0); count_o = count.
- **Latency:**
  - Store to memory is at least 1 cycle after acceptance when no loads intervene.
  - Load result is 0 cycles (combinational).

Decomposition:
- Package sb_pkg holds:
  - the DEPTH, ADDR_W and DATA_W defaults;
  - the sb_entry_t struct {addr, data};
  - the pointer-width localparam.
- One sub-module, sb_fwd_match: a youngest-first priority match across the entries, given head and count. It outputs hit and data.

Test Plan:
1. rst_i=0 for 2 cycles after random traffic → count_o=0, empty_o=1, mem_wr_o=0, stall_o=0.
2. Store 0x10←0xDEADBEEF, no loads → next cycle mem_wr_o=1, mem_adr_o=0x10, mem_data_o=0xDEADBEEF. Following cycle empty_o=1.
3. Store 0x20←0x11111111, then 0x20←0x22222222, with load_valid_i held on 0x20 (drain blocked) → load_data_o=0x22222222, load_fwd_o=1, count_o=2.
4. DEPTH=4: fill 4 stores while loads block drain, then a 5th store with a load → stall_o=1, count_o=4. Drop the load → the 5th store is accepted while the head drains, and count_o stays 4.
5. Buffer holds 0x20 and a load of 0x40 is issued, memory returning 0xCAFEF00D → mem_re_o=1, mem_adr_o=0x40, load_data_o=0xCAFEF00D, load_fwd_o=0.
6. 3 stores buffered, rst_i=0 for one edge → count_o=0, and no mem_wr_o pulse for those addresses afterwards.
